serial_adder: RTL and testbench

- Bit-serial N-bit adder that consumes the half-adder cell's sum/carry outputs. One full-adder slice is built from two half-adder stages plus an OR.
- A carry flip-flop carries the result between bit positions. Operands are processed LSB-first, one bit per clock.
- Sits directly downstream of the half-adder cell. Provides an area-cheap multi-bit add with a start/done handshake for control logic.

---
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Each bit is produced by one full-adder slice, built from two half-adder
// stages plus an OR. A carry flip-flop links successive bit positions.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   a, b, cin    operands and carry-in, captured on an accepted start
//   busy         high while bits are being processed (state RUN)
//   done         one-cycle pulse when sum/cout take a new value
//   sum, cout    registered result, held until the next done
//   dbg_state_o  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: start is accepted only on a rising edge where the FSM is in
// IDLE, i.e. busy=0 and done=0 in the preceding cycle. A start seen in RUN
// or DONE is dropped, not queued. done marks the single cycle in which a new
// {cout,sum} is first visible. The result is {cout,sum} = a + b + cin.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic             cff_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;

  // Full-adder slice: two cascaded half adders, carries merged by an OR.
  logic             ha1_sum;
  logic             ha1_carry;
  logic             ha2_sum;
  logic             ha2_carry;
  logic             bit_carry_d;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    ha1_sum     = sh_a_q[0] ^ sh_b_q[0];
    ha1_carry   = sh_a_q[0] & sh_b_q[0];
    ha2_sum     = ha1_sum ^ cff_q;
    ha2_carry   = ha1_sum & cff_q;
    bit_carry_d = ha1_carry | ha2_carry;
    // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    acc_d       = {ha2_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cff_q   <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_a_q  <= a;
            sh_b_q  <= b;
            cff_q   <= cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          sh_a_q <= {1'b0, sh_a_q[WIDTH-1:1]};
          sh_b_q <= {1'b0, sh_b_q[WIDTH-1:1]};
          cff_q  <= bit_carry_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          // Last bit: publish the whole result at once, never a partial one.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            sum_q   <= acc_d;
            cout_q  <= bit_carry_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8). Drivers push the expected {cout,sum}
// into exp_q when a start is issued to an idle DUT; a monitor on the falling
// edge pops and compares on every done pulse, and between pulses checks that
// the published result holds its last value.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  logic [W:0]   exp_q[$];
  logic [W:0]   held_exp;
  logic         prev_done;
  int           n_checks;
  int           n_errors;
  int           done_cnt;
  int           cyc;

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .cout        (cout),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          held_exp = exp_q.pop_front();
          chk("result", {cout, sum}, held_exp);
        end
        chk("busy_done_excl", busy & done, 0);
        chk("done_width", prev_done & done, 0);
      end else begin
        chk("result_hold", {cout, sum}, held_exp);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 1, 0);
    t = cyc;
  endtask

  // Issue one operation at an idle falling edge; operands are scrambled
  // right after capture to show they do not affect the sum in flight.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    wait_idle();
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    exp_q.push_back(model(x, y, c));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_n;
    int done_at;
    int t_prev;
    int t_now;
    int d0;

    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    cyc       = 0;
    held_exp  = '0;
    prev_done = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    rst_n = 1'b1;

    // 1: FF + 01 -> 00 carry 1, with latency measurement
    wait_idle();
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h100);
    @(posedge clk);
    busy_n  = 0;
    done_at = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy) busy_n++;
      if (done && done_at == 0) done_at = n;
    end
    chk("t1_busy_cycles", busy_n, 8);
    chk("t1_done_cycle", done_at, 9);

    // 2: two back-to-back results; old value must hold until new done
    do_op(8'hA5, 8'h5A, 1'b0);
    drain();
    do_op(8'h00, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    chk("t2_hold_mid_run", {cout, sum}, 9'h0FF);
    drain();

    // 3: start while busy is ignored; exactly one done
    d0 = done_cnt;
    do_op(8'h12, 8'h34, 1'b1);
    repeat (3) @(negedge clk);
    a = 8'hEE; b = 8'hEE; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("t3_single_done", done_cnt - d0, 1);

    // 4: start held high -> one result every WIDTH+2 cycles
    wait_idle();
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    exp_q.push_back(9'h101);
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(t_now);
      if (i > 0) chk("t4_period", t_now - t_prev, W + 2);
      t_prev = t_now;
      if (i < 3) exp_q.push_back(9'h101);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_no_extra", exp_q.size(), 0);

    // 5: reset mid-run, then a fresh operation
    d0 = done_cnt;
    do_op(8'h77, 8'h66, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    held_exp = '0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_sum", sum, 0);
    chk("t5_rst_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_spurious_done", done_cnt - d0, 0);
    do_op(8'h0F, 8'hF0, 1'b0);
    drain();

    // 6: randomised operations with random gaps
    for (int i = 0; i < 500; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
